// File: rtl/montgomery_exp.sv
// Modular exponentiation x^e mod m, left-to-right square-and-multiply over an external Montgomery multiplier.
// Latency: 1 + EXP_WIDTH + popcount(e) + 1 multiplier calls plus a few control cycles; multiplier stalls by holding mm_done low.
// Optional MONTEXP_SKIP_LZ_EN: starts the scan at the most-significant set bit of e.
module montgomery_exp #(
    parameter int WIDTH     = 1024,
    parameter int EXP_WIDTH = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [WIDTH-1:0]     in_r2,
    output logic [WIDTH-1:0]     result,
    output logic                 done,
    output logic                 busy,
    output logic                 mm_start,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_m,
    input  logic [WIDTH-1:0]     mm_result,
    input  logic                 mm_done
);

    localparam int IW = $clog2(EXP_WIDTH) + 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TOMONT, S_SQUARE, S_MULT, S_STEP, S_FROMMONT, S_DONE
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]     r_r;
    logic [WIDTH-1:0]     r_r2;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_xm;
    logic [EXP_WIDTH-1:0] r_e;
    logic [IW-1:0]        r_i;
    logic                 w_ebit;

    assign w_ebit = r_e[r_i[IW-2:0]];

`ifdef MONTEXP_SKIP_LZ_EN
    logic [IW-1:0] w_msb;
    logic          w_ezero;

    always_comb begin
        w_msb = '0;
        for (int k = 0; k < EXP_WIDTH; k++) begin
            if (r_e[k]) w_msb = IW'(k);
        end
    end

    assign w_ezero = (r_e == '0);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_r      <= '0;
            r_r2     <= '0;
            r_a      <= '0;
            r_xm     <= '0;
            r_e      <= '0;
            r_i      <= '0;
            result   <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            mm_start <= 1'b0;
            mm_a     <= '0;
            mm_b     <= '0;
            mm_m     <= '0;
        end else begin
            mm_start <= 1'b0;
            done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x     <= in_x;
                        r_e     <= in_e;
                        r_r     <= in_r;
                        r_r2    <= in_r2;
                        mm_m    <= in_m;
                        busy    <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
`ifdef MONTEXP_SKIP_LZ_EN
                    r_i <= w_msb;
`else
                    r_i <= IW'(EXP_WIDTH - 1);
`endif
                    r_a      <= r_r;
                    mm_a     <= r_x;
                    mm_b     <= r_r2;
                    mm_start <= 1'b1;
                    r_state  <= S_TOMONT;
                end
                S_TOMONT: begin
                    if (mm_done) begin
                        r_xm     <= mm_result;
                        mm_a     <= r_a;
                        mm_start <= 1'b1;
`ifdef MONTEXP_SKIP_LZ_EN
                        // A zero exponent leaves A as the Montgomery one; convert it straight back.
                        if (w_ezero) begin
                            mm_b    <= ONE;
                            r_state <= S_FROMMONT;
                        end else begin
                            mm_b    <= r_a;
                            r_state <= S_SQUARE;
                        end
`else
                        mm_b    <= r_a;
                        r_state <= S_SQUARE;
`endif
                    end
                end
                S_SQUARE: begin
                    if (mm_done) begin
                        r_a <= mm_result;
                        if (w_ebit) begin
                            mm_a     <= mm_result;
                            mm_b     <= r_xm;
                            mm_start <= 1'b1;
                            r_state  <= S_MULT;
                        end else begin
                            r_state <= S_STEP;
                        end
                    end
                end
                S_MULT: begin
                    if (mm_done) begin
                        r_a     <= mm_result;
                        r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    mm_a     <= r_a;
                    mm_start <= 1'b1;
                    if (r_i == '0) begin
                        mm_b    <= ONE;
                        r_state <= S_FROMMONT;
                    end else begin
                        r_i     <= r_i - 1'b1;
                        mm_b    <= r_a;
                        r_state <= S_SQUARE;
                    end
                end
                S_FROMMONT: begin
                    if (mm_done) begin
                        result  <= mm_result;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_exp.sv
// Bench for montgomery_exp: behavioural Montgomery multiplier on the mm_* ports with random 1-20 cycle latency,
// checked against a plain right-to-left modular exponentiation model.
module tb_montgomery_exp;

    localparam int W  = 64;
    localparam int EW = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [W-1:0]  in_x, in_m, in_r, in_r2;
    logic [EW-1:0] in_e;
    logic [W-1:0]  result;
    logic          done, busy, mm_start;
    logic [W-1:0]  mm_a, mm_b, mm_m;
    logic [W-1:0]  mm_result;
    logic          mm_done;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int stab_err = 0;
    int ovl_err = 0;

    montgomery_exp #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
        .result(result), .done(done), .busy(busy),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
        logic [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        return W'(p % (2*W)'(m));
    endfunction

    // a*b*2^-W mod m: multiply, then halve W times modulo the odd m.
    function automatic logic [W-1:0] montmul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
        logic [W:0] t;
        t = {1'b0, mulmod(a, b, m)};
        for (int k = 0; k < W; k++) begin
            if (t[0]) t = t + {1'b0, m};
            t = t >> 1;
        end
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] r_of(input logic [W-1:0] m);
        logic [2*W-1:0] big;
        big = (2*W)'(1) << W;
        return W'(big % (2*W)'(m));
    endfunction

    function automatic logic [W-1:0] modexp(input logic [W-1:0] x, input logic [EW-1:0] e, input logic [W-1:0] m);
        logic [W-1:0] res, base;
        res  = W'(1) % m;
        base = x % m;
        for (int k = 0; k < EW; k++) begin
            if (e[k]) res = mulmod(res, base, m);
            base = mulmod(base, base, m);
        end
        return res;
    endfunction

    function automatic int exp_calls(input logic [EW-1:0] e);
`ifdef MONTEXP_SKIP_LZ_EN
        int msb = -1;
        for (int k = 0; k < EW; k++) if (e[k]) msb = k;
        if (msb < 0) return 2;
        return 2 + msb + 1 + $countones(e);
`else
        return 2 + EW + $countones(e);
`endif
    endfunction

    // Multiplier model: one outstanding call, operands must hold until mm_done.
    initial begin
        logic [W-1:0] ca, cb, cm;
        int dly;
        mm_done   = 1'b0;
        mm_result = '0;
        forever begin
            @(negedge clk);
            mm_done = 1'b0;
            if (resetn === 1'b1 && mm_start === 1'b1) begin
                start_cnt++;
                ca  = mm_a;
                cb  = mm_b;
                cm  = mm_m;
                dly = int'($urandom_range(1, 20));
                for (int k = 0; k < dly; k++) begin
                    @(negedge clk);
                    if (!resetn) break;
                    if (mm_a !== ca || mm_b !== cb || mm_m !== cm || mm_start !== 1'b0) stab_err++;
                end
                if (resetn) begin
                    mm_result = montmul(ca, cb, cm);
                    mm_done   = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (busy && done) ovl_err++;
            if (done) done_cnt++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] x, input logic [EW-1:0] e, input logic [W-1:0] m);
        logic [W-1:0] r;
        @(negedge clk);
        r         = r_of(m);
        in_x      = x;
        in_e      = e;
        in_m      = m;
        in_r      = r;
        in_r2     = mulmod(r, r, m);
        start_cnt = 0;
        done_cnt  = 0;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(output logic [W-1:0] res, output bit ok);
        ok  = 1'b0;
        res = '0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (done) begin
                res = result;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_check(input string name, input logic [W-1:0] x, input logic [EW-1:0] e,
                             input logic [W-1:0] m, input logic [W-1:0] exp_res);
        logic [W-1:0] res;
        bit ok;
        launch(x, e, m);
        wait_done(res, ok);
        check({name, "_timeout"}, W'(ok), W'(1));
        check({name, "_result"}, res, exp_res);
        repeat (3) @(negedge clk);
        check({name, "_done_pulses"}, W'(done_cnt), W'(1));
        check({name, "_mm_calls"}, W'(start_cnt), W'(exp_calls(e)));
        check({name, "_busy_after"}, W'(busy), W'(0));
        check({name, "_operand_stability"}, W'(stab_err), W'(0));
        check({name, "_busy_done_overlap"}, W'(ovl_err), W'(0));
    endtask

    typedef struct {
        logic [W-1:0]  x;
        logic [EW-1:0] e;
        logic [W-1:0]  m;
        logic [W-1:0]  res;
    } vec_t;

    initial begin
        vec_t tbl[4];
        logic [W-1:0]  x, m, res;
        logic [EW-1:0] e;
        bit ok;
        int calls0;

        tbl[0] = '{x: 64'd5, e: 32'd3, m: 64'd13, res: 64'd8};
        tbl[1] = '{x: 64'd5, e: 32'd0, m: 64'd13, res: 64'd1};
        tbl[2] = '{x: 64'd0, e: 32'd7, m: 64'd13, res: 64'd0};
        tbl[3] = '{x: 64'd5, e: 32'd1, m: 64'd13, res: 64'd5};

        resetn = 1'b0;
        start  = 1'b0;
        in_x   = '0;
        in_e   = '0;
        in_m   = '0;
        in_r   = '0;
        in_r2  = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", W'({done, busy, mm_start}), W'(0));
        check("reset_result", result, '0);
        check("reset_mm_ops", mm_a | mm_b | mm_m, '0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_check($sformatf("vec%0d", i), tbl[i].x, tbl[i].e, tbl[i].m, tbl[i].res);
        end

        // A second start while busy must be ignored.
        launch(64'd5, 32'd3, 64'd13);
        repeat (10) @(negedge clk);
        calls0 = start_cnt;
        in_x   = 64'd7;
        in_e   = 32'd5;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        check("busy_during_run", W'(busy), W'(1));
        wait_done(res, ok);
        check("ignored_start_timeout", W'(ok), W'(1));
        check("ignored_start_result", res, 64'd8);
        repeat (30) @(negedge clk);
        check("ignored_start_no_rerun", W'(busy), W'(0));
        check("ignored_start_calls", W'(start_cnt), W'(exp_calls(32'd3)));
        check("ignored_start_done_pulses", W'(done_cnt), W'(1));
        if (calls0 < 1) check("ignored_start_progress", W'(calls0), W'(1));

        // Asynchronous reset mid-exponentiation.
        launch(64'd5, 32'hFFFF_FFFF, 64'd13);
        repeat (40) @(negedge clk);
        check("busy_before_abort", W'(busy), W'(1));
        #2;
        resetn = 1'b0;
        #1;
        check("abort_ctrl", W'({done, busy, mm_start}), W'(0));
        check("abort_result", result, '0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        run_check("after_reset", 64'd5, 32'd3, 64'd13, 64'd8);

        for (int n = 0; n < 20; n++) begin
            m = {$urandom(), $urandom()} | 64'd1;
            if (m < 64'd3) m = 64'd3;
            x = {$urandom(), $urandom()} % m;
            e = $urandom();
            run_check($sformatf("rand%0d", n), x, e, m, modexp(x, e, m));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
